fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue/writeback sequencer in front of `FPU_Top`. It accepts one encoded FP instruction at a time from the core over a valid/ready handshake, and registers the operands. It then drives the one-hot `sfpu_op` vector and the resolved rounding mode into `FPU_Top` for exactly one cycle. It captures the registered FPU result and presents it on a valid/ready writeback port, and it owns the sticky `fflags`/`frm` CSR state.

## Interface
- `STD`, 15: MSB of the float operand/result.
- `OPW`, 24: width of the `sfpu_op` one-hot vector.
- `clk` in 1: single clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `issue_valid` in 1 / `issue_ready` out 1: instruction handshake.
- `issue_op` in 5: op index 0..21, using the `sfpu_op` bit numbering.
- `issue_signed` in 1: selects `sfpu_op[23]` (1) or `sfpu_op[22]` (0) for ops 14/15.
- `issue_frm` in 3: instruction rounding mode; 3'b111 means dynamic.
- `issue_rs1`, `issue_rs2`, `issue_rs3` in STD+1: float operands.
- `issue_int` in 32: integer operand.
- `issue_tag` in 5: destination register tag.
- `fpu_operand_a`, `fpu_operand_b`, `fpu_operand_c` out STD+1.
- `fpu_operand_int` out 32.
- `fpu_sfpu_op` out OPW.
- `fpu_frm` out 3.
- `fpu_resultant` in STD+1.
- `fpu_result_rd` in 32.
- `fpu_s_flags` in 5.
- `wb_valid` out 1 / `wb_ready` in 1: writeback handshake.
- `wb_is_int` out 1.
- `wb_data` out 32.
- `wb_tag` out 5.
- `csr_we` in 1, `csr_wdata` in 8 (`{frm, fflags}`), `csr_rdata` out 8.
- `illegal_op` out 1: single-cycle pulse.

## Operation
- States: IDLE, EXEC, RESP, WB.
- `issue_ready` is 1 only in IDLE. Acceptance happens on `issue_valid & issue_ready` at the clock edge.
- Resolved rm is `issue_frm`, or `csr frm` when `issue_frm` is 111.
- An op is illegal when `issue_op` > 21 or the resolved rm is in {101, 110, 111}.
- Illegal op: the handshake completes, `illegal_op` pulses the next cycle, the block stays in IDLE, and FPU inputs and flags are untouched.
- Legal op, IDLE→EXEC:
  - Operands, tag and resolved rm are latched.
  - One-hot is bit `issue_op`.
  - For ops 14 and 15, bit 22 or 23 is added per `issue_signed`.
- EXEC→RESP: `fpu_sfpu_op` equals the latched one-hot during EXEC only. It is 0 in all other states, and the operand registers hold their values.
- RESP→WB, capture step:
  - Ops {7, 9, 10, 11, 14, 21}: `wb_is_int`=1 and `wb_data`=`fpu_result_rd`.
  - All other ops: `wb_is_int`=0 and `wb_data`={16'h0, `fpu_resultant`}.
  - `fflags` |= `fpu_s_flags`.
- WB→IDLE when `wb_ready`=1. `wb_valid`, `wb_data`, `wb_tag` and `wb_is_int` stay stable while `wb_ready`=0.
- CSR:
  - `csr_rdata` = {frm, fflags}, combinational.
  - `csr_we` loads both fields from `csr_wdata`.
  - If `csr_we` coincides with the RESP capture, the result is `fflags` = `csr_wdata[4:0] | fpu_s_flags`.
  - A `frm` write takes effect for instructions accepted from the next edge onward.
- Reset values: state IDLE; all `fpu_*` outputs 0; `wb_valid`, `wb_is_int`, `wb_data`, `wb_tag` 0; `illegal_op` 0; `fflags` 0; `frm` 000.
- Reset asserted mid-operation aborts the instruction immediately. No writeback and no flag update occur.

## Timing
- Accept edge t0. EXEC occupies t0–t1, and `FPU_Top` registers its result at t1. Capture happens at t2, and `wb_valid` rises after t2.
- Minimum accept-to-accept spacing is 4 cycles when `wb_ready` is held at 1.
- `issue_ready` is a registered decode of the state.
- `wb_valid` does not depend combinationally on `wb_ready`.

## Configuration
- `FPU_ISSUE_DYN_RM_EN` defined: `issue_frm`=111 resolves to the CSR `frm` field, and the `frm` field is writable.
- `FPU_ISSUE_DYN_RM_EN` undefined:
  - `issue_frm`=111 is always illegal.
  - The `frm` field reads 000 and ignores writes.
  - `fflags` behaviour is unchanged.

## Test plan
- Fadd: rs1=16'h3F80, rs2=16'h4000, frm=000 → during EXEC `fpu_sfpu_op`=24'h000001; `wb_valid` after t2 with `wb_data`=32'h00004040, `wb_is_int`=0, tag echoed.
- FCVT.W.P (op 14), signed, rs1=16'h4120 → EXEC `fpu_sfpu_op`=24'h804000; `wb_is_int`=1, `wb_data`=32'd10.
- `issue_op`=22 → `illegal_op` pulse one cycle, `fpu_sfpu_op` stays 0, `issue_ready` stays 1, no `wb_valid`.
- Dynamic rm: CSR write 8'h20 (frm=001), then issue with frm=111 → `fpu_frm`=001 in EXEC. With the macro undefined, the same issue → `illegal_op`.
- Flag accumulation: `fpu_s_flags`=5'b00001 on one op, then 5'b10000 on the next, with a simultaneous `csr_we` of 8'h02 on the second capture → `csr_rdata[4:0]`=5'b10010.
- Backpressure/reset: hold `wb_ready`=0 for 5 cycles → outputs stable and `issue_ready`=0. Assert `rst_l`=0 in EXEC → all outputs 0 and state IDLE immediately.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/writeback sequencer and fflags/frm CSR owner in front of FPU_Top.
//
// Optional feature macro: FPU_ISSUE_DYN_RM_EN
//   defined   -> issue_frm=111 resolves to the CSR frm field, frm is writable
//   undefined -> issue_frm=111 is illegal, frm reads 000 and ignores writes
//
// Ports:
//   clk, rst_l                        clock, asynchronous active-low reset
//   issue_valid/issue_ready           instruction handshake (ready only in IDLE)
//   issue_op/signed/frm               op index (sfpu_op bit), signedness for ops 14/15, rounding mode
//   issue_rs1/rs2/rs3/int/tag         operands and destination tag
//   fpu_operand_a/b/c/int             latched operands to FPU_Top
//   fpu_sfpu_op, fpu_frm              one-hot op (EXEC only) and resolved rounding mode
//   fpu_resultant/result_rd/s_flags   registered FPU results and exception flags
//   wb_valid/wb_ready                 writeback handshake
//   wb_is_int/wb_data/wb_tag          writeback payload
//   csr_we/csr_wdata/csr_rdata        {frm, fflags} CSR access
//   illegal_op                        one-cycle pulse after an illegal instruction is accepted
module fpu_issue_ctrl #(
    parameter int STD = 15,
    parameter int OPW = 24
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_op,
    input  logic            issue_signed,
    input  logic [2:0]      issue_frm,
    input  logic [STD:0]    issue_rs1,
    input  logic [STD:0]    issue_rs2,
    input  logic [STD:0]    issue_rs3,
    input  logic [31:0]     issue_int,
    input  logic [4:0]      issue_tag,
    output logic [STD:0]    fpu_operand_a,
    output logic [STD:0]    fpu_operand_b,
    output logic [STD:0]    fpu_operand_c,
    output logic [31:0]     fpu_operand_int,
    output logic [OPW-1:0]  fpu_sfpu_op,
    output logic [2:0]      fpu_frm,
    input  logic [STD:0]    fpu_resultant,
    input  logic [31:0]     fpu_result_rd,
    input  logic [4:0]      fpu_s_flags,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_is_int,
    output logic [31:0]     wb_data,
    output logic [4:0]      wb_tag,
    input  logic            csr_we,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      csr_rdata,
    output logic            illegal_op
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP, WB} state_t;
    localparam logic [OPW-1:0] ONE = OPW'(1);
    state_t           r_state, w_next;
    logic             r_issue_ready, r_illegal;
    logic [OPW-1:0]   r_onehot, w_onehot;
    logic [4:0]       r_op, r_tag, r_fflags, r_wb_tag, w_cap_flags;
    logic [2:0]       r_rm, w_rm, w_frm;
    logic [STD:0]     r_a, r_b, r_c;
    logic [31:0]      r_int, r_wb_data;
    logic             r_wb_valid, r_wb_is_int;
    logic             w_acc, w_illegal, w_legal_acc, w_cap, w_int;

`ifdef FPU_ISSUE_DYN_RM_EN
    logic [2:0] r_frm;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_frm <= 3'b000;
        else if (csr_we) r_frm <= csr_wdata[7:5];
    end
    assign w_frm = r_frm;
    assign w_rm  = (issue_frm == 3'b111) ? r_frm : issue_frm;
`else
    logic w_unused_frm;
    assign w_unused_frm = ^csr_wdata[7:5];
    assign w_frm = 3'b000;
    assign w_rm  = issue_frm;
`endif

    assign w_acc       = issue_valid && r_issue_ready;
    assign w_illegal   = (issue_op > 5'd21) || (w_rm >= 3'd5);
    assign w_legal_acc = w_acc && !w_illegal;
    assign w_cap       = (r_state == RESP);
    // Integer-destination ops return through the 32-bit result port
    assign w_int       = r_op inside {5'd7, 5'd9, 5'd10, 5'd11, 5'd14, 5'd21};
    assign w_cap_flags = w_cap ? fpu_s_flags : 5'b00000;
    // Conversions 14/15 also carry the signedness qualifier bit
    assign w_onehot    = (ONE << issue_op)
                       | (((issue_op == 5'd14) || (issue_op == 5'd15)) ? (issue_signed ? (ONE << 23) : (ONE << 22)) : '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_legal_acc ? EXEC : IDLE;
            EXEC: w_next = RESP;
            RESP: w_next = WB;
            WB:   w_next = wb_ready ? IDLE : WB;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state       <= IDLE;
            r_issue_ready <= 1'b1;
            r_illegal     <= 1'b0;
            r_onehot      <= '0;
            r_op          <= '0;
            r_tag         <= '0;
            r_rm          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_int         <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_is_int   <= 1'b0;
            r_wb_data     <= '0;
            r_wb_tag      <= '0;
            r_fflags      <= '0;
        end else begin
            r_state       <= w_next;
            r_issue_ready <= (w_next == IDLE);
            r_illegal     <= w_acc && w_illegal;
            if (w_legal_acc) begin
                r_onehot <= w_onehot;
                r_op     <= issue_op;
                r_tag    <= issue_tag;
                r_rm     <= w_rm;
                r_a      <= issue_rs1;
                r_b      <= issue_rs2;
                r_c      <= issue_rs3;
                r_int    <= issue_int;
            end
            if (w_cap) begin
                r_wb_valid  <= 1'b1;
                r_wb_is_int <= w_int;
                r_wb_data   <= w_int ? fpu_result_rd : {{(31-STD){1'b0}}, fpu_resultant};
                r_wb_tag    <= r_tag;
            end else if (r_state == WB && wb_ready) begin
                r_wb_valid  <= 1'b0;
            end
            // A CSR write replaces the sticky flags but still merges the flags captured this cycle
            r_fflags <= csr_we ? (csr_wdata[4:0] | w_cap_flags) : (r_fflags | w_cap_flags);
        end
    end

    assign issue_ready     = r_issue_ready;
    assign illegal_op      = r_illegal;
    assign fpu_sfpu_op     = (r_state == EXEC) ? r_onehot : '0;
    assign fpu_frm         = r_rm;
    assign fpu_operand_a   = r_a;
    assign fpu_operand_b   = r_b;
    assign fpu_operand_c   = r_c;
    assign fpu_operand_int = r_int;
    assign wb_valid        = r_wb_valid;
    assign wb_is_int       = r_wb_is_int;
    assign wb_data         = r_wb_data;
    assign wb_tag          = r_wb_tag;
    assign csr_rdata       = {w_frm, r_fflags};
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        issue_valid = 1'b0, issue_ready, issue_signed = 1'b0;
    logic [4:0]  issue_op = '0, issue_tag = '0;
    logic [2:0]  issue_frm = '0;
    logic [15:0] issue_rs1 = '0, issue_rs2 = '0, issue_rs3 = '0;
    logic [31:0] issue_int = '0;
    logic [15:0] fpu_operand_a, fpu_operand_b, fpu_operand_c;
    logic [31:0] fpu_operand_int;
    logic [23:0] fpu_sfpu_op;
    logic [2:0]  fpu_frm;
    logic [15:0] fpu_resultant = '0;
    logic [31:0] fpu_result_rd = '0;
    logic [4:0]  fpu_s_flags = '0;
    logic        wb_valid, wb_ready = 1'b1, wb_is_int;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        csr_we = 1'b0;
    logic [7:0]  csr_wdata = '0, csr_rdata;
    logic        illegal_op;

    typedef struct packed {logic is_int; logic [31:0] data; logic [4:0] tag;} wb_t;
    wb_t q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.STD(15), .OPW(24)) dut (
        .clk(clk), .rst_l(rst_l),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_signed(issue_signed), .issue_frm(issue_frm),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
        .issue_int(issue_int), .issue_tag(issue_tag),
        .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b), .fpu_operand_c(fpu_operand_c),
        .fpu_operand_int(fpu_operand_int), .fpu_sfpu_op(fpu_sfpu_op), .fpu_frm(fpu_frm),
        .fpu_resultant(fpu_resultant), .fpu_result_rd(fpu_result_rd), .fpu_s_flags(fpu_s_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_int(wb_is_int), .wb_data(wb_data), .wb_tag(wb_tag),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .illegal_op(illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic sgn, input logic [2:0] frm,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [31:0] iv, input logic [4:0] tag,
                         input logic [23:0] exp_oh, input logic [2:0] exp_frm,
                         input logic [15:0] res, input logic [31:0] rd, input logic [4:0] fl,
                         input logic exp_int, input logic [31:0] exp_data,
                         input logic csr_cap, input logic [7:0] csr_w);
        wb_t e;
        int n;
        issue_valid = 1'b1; issue_op = op; issue_signed = sgn; issue_frm = frm;
        issue_rs1 = a; issue_rs2 = b; issue_rs3 = c; issue_int = iv; issue_tag = tag;
        fpu_resultant = res; fpu_result_rd = rd; fpu_s_flags = fl;
        q.push_back({exp_int, exp_data, tag});
        @(negedge clk);
        issue_valid = 1'b0;
        chk("exec_op", 32'(fpu_sfpu_op), 32'(exp_oh));
        chk("exec_frm", 32'(fpu_frm), 32'(exp_frm));
        chk("exec_a", 32'(fpu_operand_a), 32'(a));
        chk("exec_b", 32'(fpu_operand_b), 32'(b));
        chk("exec_c", 32'(fpu_operand_c), 32'(c));
        chk("exec_int", fpu_operand_int, iv);
        chk("exec_rdy", 32'(issue_ready), 32'd0);
        @(negedge clk);
        chk("resp_op", 32'(fpu_sfpu_op), 32'd0);
        chk("resp_wbv", 32'(wb_valid), 32'd0);
        if (csr_cap) begin csr_we = 1'b1; csr_wdata = csr_w; end
        n = 0;
        @(negedge clk);
        csr_we = 1'b0;
        while (!wb_valid && n < 8) begin @(negedge clk); n++; end
        chk("wb_lat", n, 32'd0);
        if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
            e = q.pop_front();
            chk("wb_is_int", 32'(wb_is_int), 32'(e.is_int));
            chk("wb_data", wb_data, e.data);
            chk("wb_tag", 32'(wb_tag), 32'(e.tag));
        end
        if (wb_ready) begin
            @(negedge clk);
            chk("wb_done", 32'(wb_valid), 32'd0);
            chk("rdy_back", 32'(issue_ready), 32'd1);
        end
    endtask

    task automatic do_ill(input logic [4:0] op, input logic [2:0] frm);
        issue_valid = 1'b1; issue_op = op; issue_frm = frm; issue_rs1 = 16'hBEEF;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_sfpu", 32'(fpu_sfpu_op), 32'd0);
        chk("ill_rdy", 32'(issue_ready), 32'd1);
        @(negedge clk);
        chk("ill_clr", 32'(illegal_op), 32'd0);
        chk("ill_wbv", 32'(wb_valid), 32'd0);
        chk("ill_sfpu2", 32'(fpu_sfpu_op), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(issue_ready), 32'd1);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_sfpu", 32'(fpu_sfpu_op), 32'd0);
        chk("rst_csr", 32'(csr_rdata), 32'd0);
        chk("rst_ill", 32'(illegal_op), 32'd0);
        chk("rst_wbd", wb_data, 32'd0);
        rst_l = 1'b1;
        @(negedge clk);
        // fadd
        do_op(5'd0, 1'b0, 3'b000, 16'h3F80, 16'h4000, 16'h0000, 32'd0, 5'd5,
              24'h000001, 3'b000, 16'h4040, 32'd0, 5'b00001, 1'b0, 32'h00004040, 1'b0, 8'h00);
        chk("csr_f1", 32'(csr_rdata), 32'h01);
        // signed fcvt.w
        do_op(5'd14, 1'b1, 3'b001, 16'h4120, 16'h0000, 16'h0000, 32'd0, 5'd12,
              24'h804000, 3'b001, 16'h0000, 32'd10, 5'b00000, 1'b1, 32'd10, 1'b0, 8'h00);
        do_ill(5'd22, 3'b000);
        do_ill(5'd1, 3'b101);
        chk("csr_ill", 32'(csr_rdata), 32'h01);
        // flag accumulation with CSR write on the capture edge
        do_op(5'd2, 1'b0, 3'b010, 16'h1111, 16'h2222, 16'h3333, 32'd0, 5'd9,
              24'h000004, 3'b010, 16'h1234, 32'd0, 5'b10000, 1'b0, 32'h00001234, 1'b1, 8'h02);
        chk("csr_acc", 32'(csr_rdata), 32'h12);
        do_op(5'd21, 1'b0, 3'b100, 16'h0001, 16'h0002, 16'h0003, 32'h0BADF00D, 5'd31,
              24'h200000, 3'b100, 16'h5555, 32'hDEADBEEF, 5'b00000, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00);
        do_op(5'd15, 1'b0, 3'b011, 16'hC000, 16'h0000, 16'h0000, 32'd0, 5'd1,
              24'h408000, 3'b011, 16'hABCD, 32'h11111111, 5'b00000, 1'b0, 32'h0000ABCD, 1'b0, 8'h00);
        chk("csr_keep", 32'(csr_rdata), 32'h12);
        csr_we = 1'b1; csr_wdata = 8'h20;
        @(negedge clk);
        csr_we = 1'b0;
`ifdef FPU_ISSUE_DYN_RM_EN
        chk("csr_frm", 32'(csr_rdata), 32'h20);
        do_op(5'd0, 1'b0, 3'b111, 16'h3F80, 16'h3F80, 16'h0000, 32'd0, 5'd7,
              24'h000001, 3'b001, 16'h4000, 32'd0, 5'b00000, 1'b0, 32'h00004000, 1'b0, 8'h00);
`else
        chk("csr_frm", 32'(csr_rdata), 32'h00);
        do_ill(5'd0, 3'b111);
`endif
        // backpressure
        wb_ready = 1'b0;
        do_op(5'd7, 1'b0, 3'b010, 16'h0F0F, 16'h0000, 16'h0000, 32'd0, 5'd3,
              24'h000080, 3'b010, 16'h0000, 32'h00000077, 5'b00000, 1'b1, 32'h00000077, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_wbv", 32'(wb_valid), 32'd1);
            chk("bp_data", wb_data, 32'h77);
            chk("bp_tag", 32'(wb_tag), 32'd3);
            chk("bp_rdy", 32'(issue_ready), 32'd0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", 32'(wb_valid), 32'd0);
        chk("bp_rdy1", 32'(issue_ready), 32'd1);
        // reset during EXEC
        issue_valid = 1'b1; issue_op = 5'd3; issue_frm = 3'b100; issue_rs1 = 16'h7777;
        fpu_s_flags = 5'b11111;
        @(negedge clk);
        issue_valid = 1'b0;
        chk("pre_rst_op", 32'(fpu_sfpu_op), 32'h8);
        rst_l = 1'b0;
        #1;
        chk("ar_sfpu", 32'(fpu_sfpu_op), 32'd0);
        chk("ar_a", 32'(fpu_operand_a), 32'd0);
        chk("ar_frm", 32'(fpu_frm), 32'd0);
        chk("ar_wbd", wb_data, 32'd0);
        chk("ar_csr", 32'(csr_rdata), 32'd0);
        chk("ar_rdy", 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar_nowb", 32'(wb_valid), 32'd0);
        end
        chk("ar_flags", 32'(csr_rdata), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
